// File: rtl/ad_frame_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ad_frame_reader_pkg
//  Description : Shared widths, FSM state encoding and helpers for the AD
//                frame reader (cache read-side framer).
//  Revision    : 1.0  initial release
// ============================================================================
package ad_frame_reader_pkg;

  // Sample width and cache half-buffer size of the AD capture path
  localparam int AD_DATA_NBIT     = 16;
  localparam int AD_CHE_DATA_SIZE = 8;

  // Frame sequence counter and checksum widths
  localparam int SEQ_W = 8;
  localparam int SUM_W = 16;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  // Framer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_TRL   = 3'd4
  } fsm_state_t;

  // Saturating 8-bit increment used by the dropped-frame counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ad_frame_fifo
//  Description : Small synchronous first-word-fall-through FIFO carrying
//                {sof, eof, data}. A push while full is accepted only when a
//                pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module ad_frame_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage write; contents cleared so the head word is defined after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping, pointers wrap at DEPTH-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ad_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ad_frame_reader
//  Description : Reads one cache half-buffer per switch pulse and emits it as
//                a valid/ready frame: header {seq}, FRAME_LEN samples and,
//                with AD_FRAME_CKSUM_EN defined, a 16-bit wrapping sum
//                trailer. Cache reads are credit-limited against the output
//                FIFO so backpressure never loses or duplicates a sample.
//  Options     : AD_FRAME_CKSUM_EN - append checksum trailer (eof on trailer)
//  Revision    : 1.0  initial release
// ============================================================================
module ad_frame_reader
  import ad_frame_reader_pkg::*;
#(
  parameter int DATA_W    = AD_DATA_NBIT,
  parameter int FRAME_LEN = AD_CHE_DATA_SIZE,
  parameter int RD_LAT    = 2,
  parameter int FIFO_DEP  = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cache_switch,
  output logic              cache_rd,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eof,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [7:0]        drop_cnt
);

  localparam int FCW = $clog2(FIFO_DEP + 1);
  localparam int RCW = $clog2(FRAME_LEN);

  fsm_state_t        r_state;
  fsm_state_t        w_next;
  logic [RCW-1:0]    r_rd_cnt;
  logic [RCW-1:0]    r_cap_cnt;
  logic [RD_LAT-1:0] r_pipe;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_overrun;
  logic [7:0]        r_drop_cnt;

  logic              w_rd;
  logic              w_push;
  logic [DATA_W+1:0] w_push_word;
  logic              w_cap;
  logic              w_cap_eof;
  logic              w_drop;
  logic [FCW-1:0]    w_inflight;
  logic [FCW-1:0]    w_free;

  logic [DATA_W+1:0] w_fifo_rdata;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [FCW-1:0]    w_fifo_count;

`ifdef AD_FRAME_CKSUM_EN
  logic [SUM_W-1:0]  r_sum;
`endif

  // The oldest in-flight read returns its data this cycle
  assign w_cap  = r_pipe[RD_LAT-1];
  assign w_drop = cache_switch && (r_state != ST_IDLE);
  assign w_free = FCW'(FIFO_DEP) - w_fifo_count;

`ifdef AD_FRAME_CKSUM_EN
  assign w_cap_eof = LOW;
`else
  assign w_cap_eof = (r_cap_cnt == RCW'(FRAME_LEN - 1));
`endif

  // Count reads still travelling through the cache latency
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + FCW'(r_pipe[i]);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state, cache read issue and FIFO push selection
  always_comb begin
    w_next      = r_state;
    w_rd        = LOW;
    w_push      = LOW;
    w_push_word = '0;
    if (w_cap) begin
      w_push      = HIGH;
      w_push_word = {LOW, w_cap_eof, cache_rdata};
    end
    case (r_state)
      ST_IDLE: begin
        if (cache_switch) w_next = ST_HDR;
      end
      ST_HDR: begin
        // Header waits for room if the previous frame is still queued
        if (!w_fifo_full) begin
          w_push      = HIGH;
          w_push_word = {HIGH, LOW, DATA_W'(r_seq)};
          w_next      = ST_READ;
        end
      end
      ST_READ: begin
        // Every outstanding read is guaranteed a FIFO slot on return
        if (w_free > w_inflight) begin
          w_rd = HIGH;
          if (r_rd_cnt == RCW'(FRAME_LEN - 1)) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_pipe == '0) begin
`ifdef AD_FRAME_CKSUM_EN
          w_next = ST_TRL;
`else
          w_next = ST_IDLE;
`endif
        end
      end
`ifdef AD_FRAME_CKSUM_EN
      ST_TRL: begin
        if (!w_fifo_full) begin
          w_push      = HIGH;
          w_push_word = {LOW, HIGH, DATA_W'(r_sum)};
          w_next      = ST_IDLE;
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // In-flight read tracker: one bit per cycle of cache latency
  generate
    if (RD_LAT == 1) begin : g_pipe_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pipe <= '0;
        else        r_pipe <= w_rd;
      end
    end else begin : g_pipe_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pipe <= '0;
        else        r_pipe <= {r_pipe[RD_LAT-2:0], w_rd};
      end
    end
  endgenerate

  // Per-frame read/capture counters and the frame sequence number
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt  <= '0;
      r_cap_cnt <= '0;
      r_seq     <= '0;
    end else begin
      if (r_state == ST_HDR) begin
        r_rd_cnt  <= '0;
        r_cap_cnt <= '0;
      end else begin
        if (w_rd)  r_rd_cnt  <= r_rd_cnt + 1'b1;
        if (w_cap) r_cap_cnt <= r_cap_cnt + 1'b1;
      end
      if ((r_state == ST_DRAIN) && (r_pipe == '0)) r_seq <= r_seq + 1'b1;
    end
  end

`ifdef AD_FRAME_CKSUM_EN
  // Wrapping sum of the captured samples for the trailer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_sum <= '0;
    else if (r_state == ST_HDR) r_sum <= '0;
    else if (w_cap)             r_sum <= r_sum + SUM_W'(cache_rdata);
  end
`endif

  // Overrun flag (a set beats a same-cycle clear) and dropped-frame count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun  <= LOW;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop)           r_overrun <= HIGH;
      else if (overrun_clr) r_overrun <= LOW;
      if (w_drop) r_drop_cnt <= sat_inc8(r_drop_cnt);
    end
  end

  ad_frame_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEP)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_push_word),
    .pop   (m_ready),
    .rdata (w_fifo_rdata),
    .empty (w_fifo_empty),
    .full  (w_fifo_full),
    .count (w_fifo_count)
  );

  assign cache_rd = w_rd;
  assign m_valid  = !w_fifo_empty;
  assign m_data   = w_fifo_rdata[DATA_W-1:0];
  assign m_sof    = !w_fifo_empty && w_fifo_rdata[DATA_W+1];
  assign m_eof    = !w_fifo_empty && w_fifo_rdata[DATA_W];
  assign overrun  = r_overrun;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ad_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad_frame_reader
//  Description : Scoreboard bench for ad_frame_reader with a latency-2 cache
//                model. Honours AD_FRAME_CKSUM_EN for the expected trailer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ad_frame_reader;
  import ad_frame_reader_pkg::*;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 8;
  localparam int RD_LAT    = 2;
  localparam int FIFO_DEP  = 4;
`ifdef AD_FRAME_CKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cache_switch = 1'b0;
  logic              cache_rd;
  logic [DATA_W-1:0] cache_rdata = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_sof;
  logic              m_eof;
  logic              overrun;
  logic              overrun_clr = 1'b0;
  logic [7:0]        drop_cnt;

  always #5 clk = ~clk;

  ad_frame_reader #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .RD_LAT(RD_LAT), .FIFO_DEP(FIFO_DEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cache_switch(cache_switch), .cache_rd(cache_rd),
    .cache_rdata(cache_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eof(m_eof), .overrun(overrun), .overrun_clr(overrun_clr),
    .drop_cnt(drop_cnt)
  );

  // Cache model: address resets on switch, data appears two cycles after rd
  logic [DATA_W-1:0] cache_mem [FRAME_LEN];
  logic [2:0]        c_addr = '0;
  logic [DATA_W-1:0] c_stage = '0;
  int                rd_pulses = 0;
  always @(posedge clk) begin
    if (cache_switch) c_addr <= '0;
    else if (cache_rd) c_addr <= c_addr + 3'd1;
    if (cache_rd) begin
      c_stage   <= cache_mem[c_addr];
      rd_pulses <= rd_pulses + 1;
    end
    cache_rdata <= c_stage;
  end

  logic [DATA_W+1:0] sb[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_xfer = 0;
  bit tog    = 1'b0;
  int rd0;
  int x0;
  int n;

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) m_ready = ~m_ready;
  endtask

  task automatic pulse();
    cache_switch = 1'b1;
    step();
    cache_switch = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_frame(input logic [7:0] seq);
    logic [15:0] sum;
    sum = '0;
    sb.push_back({1'b1, 1'b0, DATA_W'(seq)});
    for (int i = 0; i < FRAME_LEN; i++) begin
      sum = sum + cache_mem[i];
      sb.push_back({1'b0, (i == FRAME_LEN - 1) && !CKS, cache_mem[i]});
    end
    if (CKS) sb.push_back({1'b0, 1'b1, sum});
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || m_valid) && k < 2000) begin
      step();
      k++;
    end
    n_cmp++;
    if (k >= 2000) begin
      n_fail++;
      $display("FAIL %s_timeout actual=%0d_pending required=0", name, sb.size());
    end
    repeat (6) step();
  endtask

  initial begin
    // Monitor: every accepted stream word is checked against the scoreboard
    fork
      forever begin
        logic [DATA_W+1:0] e;
        @(negedge clk);
        if (rst_n && m_valid && m_ready) begin
          n_xfer++;
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_word actual={sof%0b,eof%0b,%0h} required=none", m_sof, m_eof, m_data);
          end else begin
            e = sb.pop_front();
            if ({m_sof, m_eof, m_data} !== e) begin
              n_fail++;
              $display("FAIL stream_word actual={sof%0b,eof%0b,%0h} required={sof%0b,eof%0b,%0h}",
                       m_sof, m_eof, m_data, e[DATA_W+1], e[DATA_W], e[DATA_W-1:0]);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) step();
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_cache_rd", 32'(cache_rd), 0);
    check("rst_sof_eof", {30'd0, m_sof, m_eof}, 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    step();

    // 1: ramp data, sink always ready, header latency
    for (int i = 0; i < FRAME_LEN; i++) cache_mem[i] = DATA_W'(i);
    m_ready = 1'b1;
    rd0 = rd_pulses;
    exp_frame(8'd0);
    pulse();
    check("hdr_not_early", 32'(m_valid), 0);
    step();
    check("hdr_latency", {30'd0, m_valid, m_sof}, 32'h3);
    wait_done("t1");
    check("t1_rd_count", rd_pulses - rd0, FRAME_LEN);

    // 2: sink ready toggling every cycle
    for (int i = 0; i < FRAME_LEN; i++) cache_mem[i] = DATA_W'(16'h0100 + i * 7);
    tog = 1'b1;
    rd0 = rd_pulses;
    exp_frame(8'd1);
    pulse();
    wait_done("t2");
    check("t2_rd_count", rd_pulses - rd0, FRAME_LEN);
    tog = 1'b0;
    m_ready = 1'b1;

    // 3: second switch 3 cycles into the frame is dropped
    for (int i = 0; i < FRAME_LEN; i++) cache_mem[i] = 16'h5A5A;
    rd0 = rd_pulses;
    x0 = n_xfer;
    exp_frame(8'd2);
    pulse();
    repeat (2) step();
    pulse();
    wait_done("t3");
    check("t3_overrun", 32'(overrun), 1);
    check("t3_drop_cnt", 32'(drop_cnt), 1);
    check("t3_words", n_xfer - x0, FRAME_LEN + 1 + 32'(CKS));
    check("t3_rd_count", rd_pulses - rd0, FRAME_LEN);

    // 4: reset while sample 4 is being presented
    for (int i = 0; i < FRAME_LEN; i++) cache_mem[i] = DATA_W'(i);
    x0 = n_xfer;
    exp_frame(8'd3);
    pulse();
    n = 0;
    while (n_xfer < x0 + 5 && n < 200) begin
      step();
      n++;
    end
    check("t4_reach_sample4", n_xfer - x0, 5);
    rst_n = 1'b0;
    sb.delete();
    step();
    check("t4_rst_valid", 32'(m_valid), 0);
    check("t4_rst_overrun", 32'(overrun), 0);
    check("t4_rst_drop", 32'(drop_cnt), 0);
    step();
    rst_n = 1'b1;
    step();
    rd0 = rd_pulses;
    exp_frame(8'd0);
    pulse();
    wait_done("t4");
    check("t4_rd_count", rd_pulses - rd0, FRAME_LEN);

    // 5: all-ones samples (trailer 16'hFFF8 when the checksum is built in)
    for (int i = 0; i < FRAME_LEN; i++) cache_mem[i] = 16'hFFFF;
    x0 = n_xfer;
    exp_frame(8'd1);
    pulse();
    wait_done("t5");
    check("t5_words", n_xfer - x0, FRAME_LEN + 1 + 32'(CKS));

    // 6: stalled frame absorbs 300 switch pulses
    for (int i = 0; i < FRAME_LEN; i++) cache_mem[i] = 16'h1234;
    m_ready = 1'b0;
    rd0 = rd_pulses;
    exp_frame(8'd2);
    pulse();
    repeat (20) step();
    check("t6_stall_rd", rd_pulses - rd0, FIFO_DEP - 1);
    check("t6_stall_cache_rd", 32'(cache_rd), 0);
    for (int i = 0; i < 300; i++) begin
      pulse();
      step();
    end
    check("t6_drop_sat", 32'(drop_cnt), 32'hFF);
    check("t6_overrun", 32'(overrun), 1);
    overrun_clr = 1'b1;
    cache_switch = 1'b1;
    step();
    overrun_clr = 1'b0;
    cache_switch = 1'b0;
    check("t6_set_wins", 32'(overrun), 1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("t6_clr_overrun", 32'(overrun), 0);
    check("t6_clr_keeps_drop", 32'(drop_cnt), 32'hFF);
    m_ready = 1'b1;
    wait_done("t6");
    check("t6_rd_count", rd_pulses - rd0, FRAME_LEN);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
